fm_sweep_gen: RTL
=================

# fm_sweep_gen

Programmable linear frequency-sweep (LFM/chirp) generator that produces the signed modulation phase increment `faza_m` consumed by the `dds_fm` phase accumulator. `faza_m` steps from a start increment by a fixed step every dwell period. It supports single-shot or repeating operation, and sawtooth or optional triangle shape. When idle it drives `faza_m = 0`, so the DDS outputs the bare carrier set by `faza_f0`.

## Interface
- `W`, 32: width of phase-increment values; matches DDS accumulator width.
- `CNT_W`, 16: width of the step-count and dwell registers.

Ports:
- `clk`  in  1  system clock, shared with `dds_fm`.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  single-cycle request to begin a sweep; honoured only in IDLE.
- `stop`  in  1  synchronous abort; honoured in any state.
- `f_start`  in  W signed  first increment value.
- `f_step`  in  W signed  increment added per step; negative values sweep down.
- `n_steps`  in  CNT_W  number of steps N; the sweep holds N+1 values.
- `dwell`  in  CNT_W  hold count D; each value lasts D+1 clocks.
- `repeat`  in  1  0 = single shot, 1 = restart continuously.
- `tri`  in  1  1 = triangle shape (only with the macro enabled).
- `faza_m`  out  W signed  registered modulation increment to the DDS.
- `busy`  out  1  high while a sweep is running.
- `done`  out  1  one-cycle pulse at each sweep completion.

## Operation
- **States:** IDLE, UP, DOWN (DOWN exists only with the macro enabled).
- **Start:** `start` in IDLE latches `f_start`, `f_step`, `n_steps`, `dwell`, `repeat` and `tri`. Later changes to these inputs are ignored until the next start. `start` while busy is ignored.
- **Dwell counter** `dc` counts 0..D. A step event fires when `dc == D`, then `dc` returns to 0.
- **UP, on a step event:**
  - If step count `sc < N`: `faza_m += f_step`, `sc++`.
  - If `sc == N`, segment end:
    - triangle with N > 0: go to DOWN, `faza_m -= f_step`, `sc = N-1`.
    - repeat sawtooth: `faza_m = f_start`, `sc = 0`, `done` pulses, stay in UP.
    - otherwise: go to IDLE, `faza_m = 0`, `done` pulses.
- **DOWN, on a step event:**
  - If `sc > 0`: `faza_m -= f_step`, `sc--`.
  - If `sc == 0`: `done` pulses. With repeat set, go to UP with `faza_m = f_start + f_step` and `sc = 1`. Otherwise go to IDLE with `faza_m = 0`.
- **Arithmetic:** modulo 2^W two's-complement wrap. No saturation and no overflow flag.
- **N = 0:** a single value is held for D+1 clocks; triangle mode degrades to sawtooth.
- **Abort:** `stop` forces IDLE next cycle with `faza_m = 0` and `busy = 0`; `done` does not pulse. If `start` and `stop` are high in the same cycle, `stop` wins.

## Timing
- **Reset values:** `faza_m = 0`, `busy = 0`, `done = 0`, state IDLE, counters 0.
- **Start latency:** `start` sampled at edge k gives `faza_m = f_start` and `busy = 1` from edge k+1.
- **Single sawtooth duration:** `busy` high for exactly (N+1)(D+1) cycles. On the following cycle `faza_m = 0`, `busy = 0` and `done = 1` together.
- **Triangle period:** 2N(D+1) cycles when repeating. The top and bottom values are each held once per period.
- **Outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.
- **Reset mid-sweep:** reset assertion clears all outputs immediately (asynchronous). Reset release takes effect at the next `clk` edge.

## Configuration
- `FM_SWEEP_TRIANGLE_EN`
  - **Defined:** the DOWN state and the `tri` input are active, as described above.
  - **Undefined:** DOWN is not synthesised and `tri` is ignored (treated as 0); sawtooth only.

## Structure
- **Package `fm_sweep_pkg`:** the state enum (IDLE/UP/DOWN) and default `W`/`CNT_W` localparams, shared with the DDS top-level wrapper.
- **Sub-module `fm_sweep_timer`:** the dwell counter. It takes a clear and load of D, and outputs a one-cycle `tick` when `dc == D`.
- **Main FSM and `faza_m` adder:** stay in `fm_sweep_gen`.

## Test plan
- **Reset:** reset asserted mid-sweep → all outputs 0 asynchronously. After release, `start` with `f_start = 1000` gives `faza_m = 1000` one cycle later.
- **Single sawtooth:** `f_start = 100`, `f_step = 10`, N = 2, D = 1 → `faza_m` reads 100,100,110,110,120,120, then 0 with `done = 1`. `busy` is high for exactly 6 cycles.
- **Repeat sawtooth with wrap:** `f_start = 0x7FFFFFF0`, `f_step = 0x10`, N = 1, D = 0, repeat → `faza_m` alternates 0x7FFFFFF0, 0x80000000. `done` pulses every 2 cycles.
- **Triangle (macro on):** `f_start = 0`, `f_step = 5`, N = 2, D = 0, repeat → 0,5,10,5,0,5,10,5,… with a 4-cycle period. Repeat the same stimulus with the macro off → sawtooth 0,5,10,0,5,10,…
- **Abort:** `stop` asserted in the third cycle of a sweep → next cycle `faza_m = 0`, `busy = 0`, no `done` pulse. `start` and `stop` in the same IDLE cycle → remains IDLE.
- **Ignored inputs:** `start` re-pulsed while busy, and `f_step` changed mid-sweep → output sequence is unchanged from the latched values.

Source files
------------

// File: rtl/fm_sweep_pkg.sv
// fm_sweep_pkg
//   Shared definitions for the FM sweep generator and the DDS top-level
//   wrapper: the sweep state encoding and the default value widths.
//   Optional feature macro used by fm_sweep_gen: FM_SWEEP_TRIANGLE_EN.
package fm_sweep_pkg;

    // Default phase-increment width (matches the DDS accumulator width).
    localparam int FM_W     = 32;
    // Default width of the step-count and dwell registers.
    localparam int FM_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } sweep_state_t;

endpackage

// File: rtl/fm_sweep_timer.sv
// fm_sweep_timer
//   Dwell counter for the sweep generator. Counts dc = 0..D and raises
//   tick for the single cycle in which dc == D (while enabled), then wraps.
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-low reset
//   load   in   capture a new dwell value D and restart the count at 0
//   clr    in   restart the count at 0 (abort)
//   en     in   count enable (sweep running)
//   dwell  in   dwell value D captured on load
//   tick   out  step event: dc == D while enabled
module fm_sweep_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] dwell,
    output logic             tick
);

    localparam logic [CNT_W-1:0] DC_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] d_reg;
    logic [CNT_W-1:0] dc_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_reg  <= '0;
            dc_reg <= '0;
        end else if (load) begin
            d_reg  <= dwell;
            dc_reg <= '0;
        end else if (clr) begin
            dc_reg <= '0;
        end else if (en) begin
            if (dc_reg == d_reg) begin
                dc_reg <= '0;
            end else begin
                dc_reg <= dc_reg + DC_ONE;
            end
        end
    end

    assign tick = en && (dc_reg == d_reg);

endmodule

// File: rtl/fm_sweep_gen.sv
// fm_sweep_gen
//   Linear frequency-sweep (chirp) generator. Produces the signed modulation
//   phase increment faza_m for the dds_fm accumulator: starts at f_start and
//   adds f_step every D+1 clocks for N steps. Single-shot or repeating,
//   sawtooth or (optionally) triangle. Drives faza_m = 0 when idle.
//   Optional feature macro: FM_SWEEP_TRIANGLE_EN (enables the DOWN state and
//   the tri_mode input; otherwise sawtooth only and tri_mode is ignored).
// Ports:
//   clk          in   system clock (shared with dds_fm)
//   rst          in   asynchronous active-low reset
//   start        in   one-cycle sweep request, honoured only when idle
//   stop         in   synchronous abort, honoured in any state (wins over start)
//   f_start      in   first increment value (signed)
//   f_step       in   increment added per step (signed, negative sweeps down)
//   n_steps      in   number of steps N; the sweep holds N+1 values
//   dwell        in   hold count D; each value lasts D+1 clocks
//   repeat_mode  in   0 = single shot, 1 = restart continuously
//   tri_mode     in   1 = triangle shape
//   faza_m       out  registered modulation increment
//   busy         out  high while a sweep is running
//   done         out  one-cycle pulse at each sweep completion
module fm_sweep_gen
    import fm_sweep_pkg::*;
#(
    parameter int W     = FM_W,
    parameter int CNT_W = FM_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic signed [W-1:0] f_start,
    input  logic signed [W-1:0] f_step,
    input  logic [CNT_W-1:0]    n_steps,
    input  logic [CNT_W-1:0]    dwell,
    input  logic                repeat_mode,
    input  logic                tri_mode,
    output logic signed [W-1:0] faza_m,
    output logic                busy,
    output logic                done
);

`ifdef FM_SWEEP_TRIANGLE_EN
    localparam logic TRI_EN = 1'b1;
`else
    localparam logic TRI_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] SC_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    sweep_state_t        state_reg, state_next;
    logic signed [W-1:0] faza_reg, faza_next;
    logic [CNT_W-1:0]    sc_reg, sc_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                start_load;

    // Parameters captured at start; later input changes are ignored.
    logic signed [W-1:0] fstart_reg;
    logic signed [W-1:0] fstep_reg;
    logic [CNT_W-1:0]    n_reg;
    logic                rpt_reg;
    logic                tri_reg;

    logic                tick;

    fm_sweep_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (start_load),
        .clr   (stop),
        .en    (state_reg != ST_IDLE),
        .dwell (dwell),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            faza_reg   <= '0;
            sc_reg     <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            fstart_reg <= '0;
            fstep_reg  <= '0;
            n_reg      <= '0;
            rpt_reg    <= 1'b0;
            tri_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            faza_reg  <= faza_next;
            sc_reg    <= sc_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            if (start_load) begin
                fstart_reg <= f_start;
                fstep_reg  <= f_step;
                n_reg      <= n_steps;
                rpt_reg    <= repeat_mode;
                // Constant zero in the sawtooth-only build, so the DOWN
                // branch below is unreachable and pruned.
                tri_reg    <= tri_mode & TRI_EN;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        faza_next  = faza_reg;
        sc_next    = sc_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        start_load = 1'b0;

        if (stop) begin
            state_next = ST_IDLE;
            faza_next  = '0;
            sc_next    = '0;
            busy_next  = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        start_load = 1'b1;
                        state_next = ST_UP;
                        faza_next  = f_start;
                        sc_next    = '0;
                        busy_next  = 1'b1;
                    end
                end
                ST_UP: begin
                    if (tick) begin
                        if (sc_reg != n_reg) begin
                            faza_next = faza_reg + fstep_reg;
                            sc_next   = sc_reg + SC_ONE;
                        end else if (tri_reg && (n_reg != '0)) begin
                            // Top of the triangle: turn around without
                            // repeating the peak value.
                            state_next = ST_DOWN;
                            faza_next  = faza_reg - fstep_reg;
                            sc_next    = n_reg - SC_ONE;
                        end else if (rpt_reg) begin
                            faza_next = fstart_reg;
                            sc_next   = '0;
                            done_next = 1'b1;
                        end else begin
                            state_next = ST_IDLE;
                            faza_next  = '0;
                            sc_next    = '0;
                            busy_next  = 1'b0;
                            done_next  = 1'b1;
                        end
                    end
                end
`ifdef FM_SWEEP_TRIANGLE_EN
                ST_DOWN: begin
                    if (tick) begin
                        if (sc_reg != '0) begin
                            faza_next = faza_reg - fstep_reg;
                            sc_next   = sc_reg - SC_ONE;
                        end else begin
                            done_next = 1'b1;
                            if (rpt_reg) begin
                                // Bottom already held: resume one step up.
                                state_next = ST_UP;
                                faza_next  = fstart_reg + fstep_reg;
                                sc_next    = SC_ONE;
                            end else begin
                                state_next = ST_IDLE;
                                faza_next  = '0;
                                sc_next    = '0;
                                busy_next  = 1'b0;
                            end
                        end
                    end
                end
`endif
                default: begin
                    state_next = ST_IDLE;
                    faza_next  = '0;
                    sc_next    = '0;
                    busy_next  = 1'b0;
                end
            endcase
        end
    end

    assign faza_m = faza_reg;
    assign busy   = busy_reg;
    assign done   = done_reg;

endmodule
